// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage RV32IM pipeline: load-use stalls of configurable
// depth, multi-cycle MUL/DIV wait, global memory-wait freeze and saturating perf counters.
module hazard_ctrl_mc #(
  parameter int REG_AW            = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [6:0]        opcode,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_load_inst,
  input  logic              ex_muldiv_busy,
  input  logic              jump_branch_taken,
  input  logic              invalid_inst,
  input  logic              mem_wait,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_mem_en,
  output logic              ex_mem_flush,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [3:0] LD_INIT = 4'(LOAD_STALL_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MD_WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic ex_mem_flush;
  } ctl_t;

  state_t     state_q, state_d;
  logic [3:0] ld_cnt_q, ld_cnt_d;
  ctl_t       ctl;
  logic       flush_inc;
  logic       rs1_used, rs2_used, load_hazard, eff_run;
  logic [CNT_W-1:0] stall_q, flush_q;

  assign rs1_used = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LD) ||
                    (opcode == OP_JALR) || (opcode == OP_ST) || (opcode == OP_BR);
  assign rs2_used = (opcode == OP_R) || (opcode == OP_ST) || (opcode == OP_BR);

  // ex_rd != 0 covers the x0 case for both operands
  assign load_hazard = ex_load_inst && (ex_rd != '0) &&
                       ((rs1_used && (id_rs1 == ex_rd)) || (rs2_used && (id_rs2 == ex_rd)));

  // MD_WAIT with the unit finished behaves like RUN for the lower-priority rules
  assign eff_run = (state_q == RUN) || ((state_q == MD_WAIT) && !ex_muldiv_busy);

  always_comb begin
    ctl.pc_en        = 1'b1;
    ctl.if_id_en     = 1'b1;
    ctl.if_id_flush  = 1'b0;
    ctl.id_ex_en     = 1'b1;
    ctl.id_ex_flush  = 1'b0;
    ctl.ex_mem_en    = 1'b1;
    ctl.ex_mem_flush = 1'b0;
    state_d   = ((state_q == MD_WAIT) && !ex_muldiv_busy) ? RUN : state_q;
    ld_cnt_d  = ld_cnt_q;
    flush_inc = 1'b0;

    if (mem_wait) begin
      ctl       = '0;
      state_d   = state_q;
    end else if (ex_muldiv_busy && (state_q != LD_STALL)) begin
      ctl.pc_en        = 1'b0;
      ctl.if_id_en     = 1'b0;
      ctl.id_ex_en     = 1'b0;
      ctl.ex_mem_flush = 1'b1;
      state_d          = MD_WAIT;
    end else if (jump_branch_taken && eff_run) begin
      ctl.if_id_flush = 1'b1;
      ctl.if_id_en    = 1'b0;
      ctl.id_ex_flush = 1'b1;
      flush_inc       = 1'b1;
    end else if ((state_q == LD_STALL) || (eff_run && load_hazard)) begin
      ctl.pc_en       = 1'b0;
      ctl.if_id_en    = 1'b0;
      ctl.id_ex_flush = 1'b1;
      if (state_q == LD_STALL) begin
        ld_cnt_d = ld_cnt_q - 4'd1;
        if (ld_cnt_q == 4'd1) state_d = RUN;
      end else if (LOAD_STALL_CYCLES > 1) begin
        ld_cnt_d = LD_INIT;
        state_d  = LD_STALL;
      end
    end else if (invalid_inst && eff_run) begin
      ctl.id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      ld_cnt_q <= 4'd0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      if (!ctl.pc_en && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc && (flush_q != '1))  flush_q <= flush_q + CNT_W'(1);
    end
  end

  // reset forces the pipeline closed with IF/ID and ID/EX flushing
  assign pc_en        = rst_n & ctl.pc_en;
  assign if_id_en     = rst_n & ctl.if_id_en;
  assign if_id_flush  = !rst_n | ctl.if_id_flush;
  assign id_ex_en     = rst_n & ctl.id_ex_en;
  assign id_ex_flush  = !rst_n | ctl.id_ex_flush;
  assign ex_mem_en    = rst_n & ctl.ex_mem_en;
  assign ex_mem_flush = rst_n & ctl.ex_mem_flush;
  assign stall_count  = stall_q;
  assign flush_count  = flush_q;

endmodule
